calc_datapath: RTL and testbench

CALC_DATAPATH -- requirements
Module: calc_datapath

---
 rtl/calc_datapath.sv | 139 +++++++++++++
 tb/tb_calc_datapath.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc_datapath.sv
// Calculator datapath: captures operands/opcode on confirm pulses, runs single-cycle
// ALU ops or a sequential shift-add multiply, and selects what the 7-segment shows.
module calc_datapath #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   estado,
    input  logic         btnc,
    input  logic [W-1:0] sw,
    output logic [W-1:0] display,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic         busy,
    output logic [2:0]   flags
);

    typedef enum logic [1:0] {
        WAIT_OP1    = 2'b00,
        WAIT_OP2    = 2'b01,
        WAIT_OP     = 2'b10,
        SHOW_RESULT = 2'b11
    } calc_state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100
    } opcode_t;

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]   op1;
    logic [W-1:0]   op2;
    logic [2:0]     opc;
    logic           single_pend;
    logic [CW-1:0]  count;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;

    logic [W:0]     sum;
    logic [W-1:0]   alu_res;
    logic           alu_ovf;

    always_comb begin
        sum     = {1'b0, op1} + {1'b0, op2};
        alu_res = '0;
        alu_ovf = 1'b0;
        case (opc)
            OP_ADD: begin
                alu_res = sum[W-1:0];
                alu_ovf = sum[W];
            end
            OP_SUB: begin
                alu_res = op1 - op2;
                alu_ovf = (op1 < op2);
            end
            OP_AND:  alu_res = op1 & op2;
            OP_OR:   alu_res = op1 | op2;
            default: begin
                alu_res = '0;
                alu_ovf = 1'b1;
            end
        endcase
    end

    // Clearing in show_result outranks everything but reset, which also aborts a multiply.
    always_ff @(posedge clk) begin
        if (reset) begin
            op1          <= '0;
            op2          <= '0;
            opc          <= '0;
            result       <= '0;
            flags        <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            single_pend  <= 1'b0;
            count        <= '0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
        end else begin
            if (btnc && estado == WAIT_OP1) op1 <= sw;
            if (btnc && estado == WAIT_OP2) op2 <= sw;

            if (btnc && estado == SHOW_RESULT) begin
                result_valid <= 1'b0;
                flags        <= '0;
                busy         <= 1'b0;
                single_pend  <= 1'b0;
            end else if (btnc && estado == WAIT_OP) begin
                opc          <= sw[2:0];
                result_valid <= 1'b0;
                if (sw[2:0] == OP_MUL) begin
                    busy        <= 1'b1;
                    single_pend <= 1'b0;
                    count       <= '0;
                    acc         <= '0;
                    mcand       <= {{W{1'b0}}, op1};
                    mplier      <= op2;
                end else begin
                    busy        <= 1'b0;
                    single_pend <= 1'b1;
                end
            end else if (single_pend) begin
                result       <= alu_res;
                flags        <= {alu_ovf, alu_res[W-1], alu_res == '0};
                result_valid <= 1'b1;
                single_pend  <= 1'b0;
            end else if (busy) begin
                // One multiplier bit per cycle; the cycle after the last bit publishes the product.
                if (count == CW'(W)) begin
                    result       <= acc[W-1:0];
                    flags        <= {|acc[2*W-1:W], acc[W-1], acc[W-1:0] == '0};
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                end else begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                end
            end
        end
    end

    always_comb begin
        display = '0;
        case (estado)
            WAIT_OP1, WAIT_OP2: display = sw;
            WAIT_OP:            display = {{(W-3){1'b0}}, sw[2:0]};
            default:            display = result_valid ? result : '0;
        endcase
    end

endmodule

// File: tb/tb_calc_datapath.sv
// Self-checking bench for calc_datapath: directed corner cases plus random operations,
// checked against an arithmetic reference model.
module tb_calc_datapath;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic [1:0]   estado;
    logic         btnc;
    logic [W-1:0] sw;
    logic [W-1:0] display;
    logic [W-1:0] result;
    logic         result_valid;
    logic         busy;
    logic [2:0]   flags;

    int check_count;
    int pass_count;
    int fail_count;
    logic [W-1:0] model_result;

    calc_datapath #(.W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .estado       (estado),
        .btnc         (btnc),
        .sw           (sw),
        .display      (display),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .flags        (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, neg, zero, result} straight from the arithmetic definitions.
    function automatic logic [18:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] op);
        longint unsigned full;
        logic [15:0] res;
        logic ovf;
        res = 16'h0;
        ovf = 1'b0;
        case (op)
            3'd0: begin
                full = longint'(a) + longint'(b);
                res  = 16'(full);
                ovf  = full > 65535;
            end
            3'd1: begin
                res = a - b;
                ovf = a < b;
            end
            3'd2: begin
                full = longint'(a) * longint'(b);
                res  = 16'(full);
                ovf  = (full >> 16) != 0;
            end
            3'd3: res = a & b;
            3'd4: res = a | b;
            default: begin
                res = 16'h0;
                ovf = 1'b1;
            end
        endcase
        return {ovf, res[15], res == 16'h0, res};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] st, input logic b, input logic [W-1:0] s);
        estado = st;
        btnc   = b;
        sw     = s;
        tick();
        btnc   = 1'b0;
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        logic [15:0] op_sw;
        estado = 2'b00;
        sw     = a;
        #1;
        check_output("display_op1_live", display, a);
        apply_stimulus(2'b00, 1'b1, a);
        apply_stimulus(2'b01, 1'b1, b);
        op_sw      = 16'($urandom());
        op_sw[2:0] = op;
        estado     = 2'b10;
        sw         = op_sw;
        #1;
        check_output("display_opcode", display, {13'h0, op});
        apply_stimulus(2'b10, 1'b1, op_sw);
        check_output("valid_clear_on_capture", result_valid, 0);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        logic [18:0] exp;
        exp = ref_op(a, b, op);
        start_op(a, b, op);
        if (op == 3'd2) begin
            for (int i = 0; i < W; i++) begin
                check_output("mul_busy", busy, 1);
                check_output("mul_valid_low", result_valid, 0);
                tick();
            end
            check_output("mul_valid_low_last", result_valid, 0);
            tick();
        end else begin
            check_output("single_not_busy", busy, 0);
            tick();
        end
        check_output("result", result, exp[15:0]);
        check_output("flags", flags, exp[18:16]);
        check_output("result_valid", result_valid, 1);
        check_output("busy_done", busy, 0);
        model_result = exp[15:0];
        estado = 2'b11;
        #1;
        check_output("display_result", display, exp[15:0]);
        apply_stimulus(2'b11, 1'b1, sw);
        check_output("clear_valid", result_valid, 0);
        check_output("clear_flags", flags, 0);
        check_output("clear_busy", busy, 0);
        check_output("result_hold", result, model_result);
        check_output("display_cleared", display, 0);
        estado = 2'b00;
    endtask

    initial begin
        logic [15:0] v;
        check_count  = 0;
        pass_count   = 0;
        fail_count   = 0;
        model_result = 16'h0;
        reset  = 1'b1;
        estado = 2'b00;
        btnc   = 1'b0;
        sw     = 16'hA5C3;
        tick();
        tick();
        check_output("reset_result", result, 0);
        check_output("reset_flags", flags, 0);
        check_output("reset_valid", result_valid, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_display", display, 16'hA5C3);
        reset = 1'b0;

        run_op(16'h0005, 16'h0003, 3'd0);
        run_op(16'hFFFF, 16'h0001, 3'd0);
        run_op(16'h0003, 16'h0005, 3'd1);
        run_op(16'h0100, 16'h0101, 3'd2);
        run_op(16'hF0F0, 16'h3C3C, 3'd3);
        run_op(16'hF0F0, 16'h0F0F, 3'd4);

        $display("[TB] mul abort from show_result");
        start_op(16'h00FF, 16'h00FF, 3'd2);
        for (int i = 0; i < 4; i++) tick();
        apply_stimulus(2'b11, 1'b1, sw);
        check_output("abort_busy", busy, 0);
        check_output("abort_valid", result_valid, 0);
        check_output("abort_result", result, model_result);
        estado = 2'b00;
        for (int i = 0; i < W + 4; i++) tick();
        check_output("abort_no_late_valid", result_valid, 0);
        check_output("abort_no_late_result", result, model_result);

        $display("[TB] reset during mul");
        start_op(16'h1234, 16'h0F0F, 3'd2);
        for (int i = 0; i < 7; i++) tick();
        estado = 2'b00;
        sw     = 16'h5A5A;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        model_result = 16'h0;
        check_output("mid_reset_result", result, 0);
        check_output("mid_reset_flags", flags, 0);
        check_output("mid_reset_valid", result_valid, 0);
        check_output("mid_reset_busy", busy, 0);
        check_output("mid_reset_display", display, 16'h5A5A);
        for (int i = 0; i < W + 4; i++) tick();
        check_output("mid_reset_no_late_valid", result_valid, 0);
        run_op(16'($urandom()), 16'($urandom()), 3'd7);

        $display("[TB] held confirm captures every cycle");
        apply_stimulus(2'b00, 1'b1, 16'h1111);
        btnc = 1'b1;
        sw   = 16'h2222;
        tick();
        sw   = 16'h3333;
        tick();
        btnc = 1'b0;
        apply_stimulus(2'b01, 1'b1, 16'h0001);
        apply_stimulus(2'b10, 1'b1, 16'h0000);
        tick();
        check_output("held_capture_last", result, 16'h3334);
        apply_stimulus(2'b11, 1'b1, sw);
        estado = 2'b00;

        $display("[TB] random operations");
        for (int n = 0; n < 16; n++) begin
            v = 16'($urandom());
            run_op(v, 16'($urandom()), 3'($urandom_range(0, 7)));
        end
        run_op(16'h8000, 16'h0002, 3'd2);
        run_op(16'h0000, 16'h0000, 3'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
